// File: rtl/lpddr2_port_arbiter_pkg.sv
// Shared definitions for the two-port LPDDR2 controller arbiter:
// FSM state encoding, requester ids and the data returned on an aborted read.
package lpddr2_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_t;

  // Requester ids: the CPU master path and the disk-to-DRAM copy client.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Read data handed back when a transaction is abandoned by the watchdog.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/lpddr2_port_arbiter_if.sv
// Bundle of requester and controller-side signals around the arbiter.
//
// Handshake semantics:
//   Requester side: p*_rreq / p*_wreq are levels held (with stable addr/wdata)
//   until the one-cycle p*_ack pulse; p*_rdata is valid with p*_ack after a read.
//   Controller side: mem_ready high means idle and accepting. A command is a
//   one-cycle mem_rreq/mem_wreq pulse issued only while mem_ready is high; the
//   controller accepts by dropping mem_ready and completes by raising it again,
//   at which point mem_rdata is valid for a read.
// The "slave" modport is the arbiter view; "master" is the surrounding system.
interface lpddr2_port_arbiter_if
  import lpddr2_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          p0_rreq;
  logic          p0_wreq;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic [DW-1:0] p0_rdata;
  logic          p0_ack;

  logic          p1_rreq;
  logic          p1_wreq;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic [DW-1:0] p1_rdata;
  logic          p1_ack;

  logic          mem_ready;
  logic          mem_rreq;
  logic          mem_wreq;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          err;
  arb_state_t    state;

  modport slave (
    input  p0_rreq, p0_wreq, p0_addr, p0_wdata,
    output p0_rdata, p0_ack,
    input  p1_rreq, p1_wreq, p1_addr, p1_wdata,
    output p1_rdata, p1_ack,
    input  mem_ready, mem_rdata,
    output mem_rreq, mem_wreq, mem_addr, mem_wdata,
    output busy, err, state
  );

  modport master (
    output p0_rreq, p0_wreq, p0_addr, p0_wdata,
    input  p0_rdata, p0_ack,
    output p1_rreq, p1_wreq, p1_addr, p1_wdata,
    input  p1_rdata, p1_ack,
    output mem_ready, mem_rdata,
    input  mem_rreq, mem_wreq, mem_addr, mem_wdata,
    input  busy, err, state
  );

endinterface

// File: rtl/lpddr2_port_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick. A lone pending port wins outright;
// with both pending, the port that did not win last time is chosen.
module rr_arbiter2
  import lpddr2_arb_pkg::*;
(
  input  logic [1:0] pending,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  // Select the winner from the pending bits and the previous grant.
  always_comb begin
    grant_valid = |pending;
    grant_id    = PORT_CPU;
    if (pending == 2'b11) begin
      grant_id = ~last_grant;
    end else if (pending[1]) begin
      grant_id = PORT_DMA;
    end
  end

endmodule

// File: rtl/lpddr2_port_arbiter.sv
// Shares one LPDDR2 controller port between the CPU path (port 0) and a DMA
// client (port 1): round-robin grant, one transaction in flight, one-cycle ack
// back to the winning requester.
// Optional watchdog: define LPDDR2_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYC cycles of waiting on the controller (sticky err, rdata DEADBEEF).
module lpddr2_port_arbiter
  import lpddr2_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef LPDDR2_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  lpddr2_port_arbiter_if.slave bus
);

  arb_state_t    state;
  logic          last_grant;
  logic          gid;
  logic          op_read;
  logic          mem_rreq_q;
  logic          mem_wreq_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          ack0_q;
  logic          ack1_q;
  logic          err_q;

  logic [1:0]    pending;
  logic          grant_valid;
  logic          grant_id;
  logic          sel_rd;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          timeout_hit;
  logic          done_now;
  logic          abort;
  logic          finish;
  logic [DW-1:0] resp_data;

  assign pending = {bus.p1_rreq | bus.p1_wreq, bus.p0_rreq | bus.p0_wreq};

  rr_arbiter2 u_rr (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Route the winning port's request; a read beats a write on the same port.
  always_comb begin
    sel_rd    = bus.p0_rreq;
    sel_addr  = bus.p0_addr;
    sel_wdata = bus.p0_wdata;
    if (grant_id == PORT_DMA) begin
      sel_rd    = bus.p1_rreq;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
    end
  end

  // Normal completion has priority over a watchdog expiry in the same cycle.
  assign done_now  = (state == WAIT_DONE) && bus.mem_ready;
  assign abort     = timeout_hit && !done_now;
  assign finish    = done_now || abort;
  assign resp_data = done_now ? bus.mem_rdata : DW'(TIMEOUT_DATA);

`ifdef LPDDR2_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             wait_st;

  assign wait_st     = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign timeout_hit = wait_st && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count cycles spent waiting on the controller; latch err on expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (wait_st) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (abort) begin
        err_q <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
`endif

  // Arbiter FSM: grant, one-cycle command, wait accept, wait done, ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= PORT_DMA;
      gid         <= PORT_CPU;
      op_read     <= 1'b0;
      mem_rreq_q  <= 1'b0;
      mem_wreq_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      mem_rreq_q <= 1'b0;
      mem_wreq_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      if (finish) begin
        if (op_read) begin
          if (gid == PORT_DMA) rdata1_q <= resp_data;
          else                 rdata0_q <= resp_data;
        end
        if (gid == PORT_DMA) ack1_q <= 1'b1;
        else                 ack0_q <= 1'b1;
        state <= RESP;
      end else begin
        case (state)
          IDLE: begin
            if (grant_valid && bus.mem_ready) begin
              gid         <= grant_id;
              last_grant  <= grant_id;
              op_read     <= sel_rd;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
              mem_rreq_q  <= sel_rd;
              mem_wreq_q  <= !sel_rd;
              state       <= ISSUE;
            end
          end
          ISSUE:     state <= WAIT_BUSY;
          WAIT_BUSY: if (!bus.mem_ready) state <= WAIT_DONE;
          WAIT_DONE: state <= WAIT_DONE;
          RESP:      state <= IDLE;
          default:   state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mem_rreq  = mem_rreq_q;
  assign bus.mem_wreq  = mem_wreq_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;
  assign bus.p0_ack    = ack0_q;
  assign bus.p1_ack    = ack1_q;
  assign bus.busy      = (state != IDLE);
  assign bus.err       = err_q;
  assign bus.state     = state;

endmodule

// File: doc/lpddr2_port_arbiter.md
Name: lpddr2_port_arbiter

Overview:
- Shares the single LPDDR2 memory controller port (read_req/write_req/addr/inData/outData plus idle state) between two requesters.
- Port 0 is the CPU master memory path; port 1 is a DMA-style client (disk-to-DRAM copy).
- Round-robin arbitration, one outstanding transaction at a time, completion handshake back to each requester.
- Sits between the requesters and the LPDDR2 controller; runs in the controller clock domain.

Parameters:
- AW, 32, address width of requesters and memory port.
- DW, 32, data width.
- TIMEOUT_CYC, 4096, cycles without completion before abort (used only with optional feature).

Ports:
- clk  in  1  controller clock (afi_half_clk domain).
- rst  in  1  asynchronous reset, active-high.
- p0_rreq  in  1  port 0 read request, level, held until p0_ack.
- p0_wreq  in  1  port 0 write request, level, held until p0_ack.
- p0_addr  in  AW  port 0 address, stable while request held.
- p0_wdata  in  DW  port 0 write data.
- p0_rdata  out  DW  port 0 read data, valid with p0_ack.
- p0_ack  out  1  one-cycle completion pulse.
- p1_rreq, p1_wreq, p1_addr, p1_wdata, p1_rdata, p1_ack: same as port 0, for port 1.
- mem_ready  in  1  controller idle and accepting (controller state == idle).
- mem_rreq  out  1  read command pulse to controller.
- mem_wreq  out  1  write command pulse to controller.
- mem_addr  out  AW  registered command address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  controller read data, valid when mem_ready returns high after a read.
- busy  out  1  high whenever state != IDLE.
- err  out  1  sticky timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, last_grant=1, so port 0 wins the first contention.
- A requester is "pending" if rreq|wreq. If both rreq and wreq are set on one port, read wins; the write remains pending for a later grant.
- States:
  - IDLE: if any port is pending and mem_ready=1, grant. With both pending, grant the port != last_grant. Register addr/wdata/op and the granted id into mem_addr/mem_wdata, update last_grant, go ISSUE. If mem_ready=0, stay in IDLE.
  - ISSUE: assert mem_rreq or mem_wreq for exactly 1 cycle, go WAIT_BUSY.
  - WAIT_BUSY: wait for mem_ready=0 (controller accepted), then go WAIT_DONE.
  - WAIT_DONE: wait for mem_ready=1. Capture mem_rdata into the granted port's rdata register (reads only), go RESP.
  - RESP: pulse the granted port's ack for 1 cycle, go IDLE.
- Latency: minimum request-to-ack is 4 cycles plus the controller busy time. There is one dead cycle (RESP) between back-to-back grants.
- p*_rdata holds its last captured value until that port's next read completes. A write does not modify rdata.
- A requester dropping its request mid-transaction does not abort it; ack is still pulsed.
- Simultaneous requests always alternate: no port waits more than one transaction.
- Reset mid-operation returns to IDLE immediately with no ack issued. Requesters must re-issue.
- mem_addr/mem_wdata remain stable from IDLE exit until the next grant.

Optional Feature:
- Macro: LPDDR2_ARB_TIMEOUT_EN.
- With the macro: a counter runs in WAIT_BUSY/WAIT_DONE. When it reaches TIMEOUT_CYC, the arbiter sets err (sticky until rst), still pulses ack (read data = 32'hDEADBEEF), and returns to IDLE through RESP.
- Without the macro: the arbiter waits indefinitely, err=0, and no counter logic is present.

Decomposition:
- Shared package lpddr2_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP);
  - port-id constants PORT_CPU=0, PORT_DMA=1;
  - timeout data constant 32'hDEADBEEF.
- One natural sub-module: rr_arbiter2, a combinational 2-way round-robin pick from pending bits and last_grant.

Test Plan:
- Single port-0 read of addr 0x100, controller busy 5 cycles, returns 0xCAFEF00D -> one p0_ack with p0_rdata=0xCAFEF00D; port 1 sees no ack and no rdata change.
- p0_wreq and p1_wreq held continuously -> grants alternate 0,1,0,1 starting with port 0 after reset; mem_wdata matches each port's data per grant.
- p1_rreq and p1_wreq both high -> read issued first, write issued on a later grant; two p1_acks.
- mem_ready held low at request time -> no mem_rreq/mem_wreq until mem_ready rises; then exactly one command pulse.
- rst asserted during WAIT_DONE -> all outputs 0 next edge, no ack; the re-issued request completes normally.
- With LPDDR2_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, mem_ready never returns -> ack after timeout, rdata=0xDEADBEEF, err=1 sticky.
